// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder, div_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  state_t         nstate;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic           dz;
  logic           accept;
  logic           last;
  logic           step;
  logic [WIDTH:0] rs;
  logic [WIDTH:0] t;
  logic [WIDTH-1:0] qs;

  assign accept = (state == IDLE) && start;
  assign last   = (state == CALC) && (cnt == '0);
  assign step   = (state == CALC) && (cnt != '0);

  // Shift {R,Q} left by one, then trial-subtract the divisor.
  assign rs = {r, q[WIDTH-1]};
  assign qs = {q[WIDTH-2:0], 1'b0};
  assign t  = rs - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = CALC;
      CALC: if (cnt == '0) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == CALC): busy = 1'b1;
      (state == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // A zero divisor preloads the saturated result and a zero step
  // count, so it skips the shift steps and finishes one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      r   <= '0;
      q   <= '0;
      dvs <= '0;
      dz  <= 1'b0;
    end else if (accept) begin
      dvs <= divisor;
      dz  <= (divisor == '0);
      if (divisor == '0) begin
        q   <= '1;
        r   <= dividend;
        cnt <= '0;
      end else begin
        q   <= dividend;
        r   <= '0;
        cnt <= CW'(WIDTH);
      end
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (!t[WIDTH]) begin
        r <= t[WIDTH-1:0];
        q <= {qs[WIDTH-1:1], 1'b1};
      end else begin
        r <= rs[WIDTH-1:0];
        q <= qs;
      end
    end
  end

  // Visible results move only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (last) begin
      quotient  <= q;
      remainder <= r;
      div_zero  <= dz;
    end
  end

endmodule
